// File: rtl/flit_tx_arbiter.sv
`default_nettype none
// ============================================================================
// flit_tx_arbiter : round-robin, packet-locked arbiter that serialises flits
//                   MSB-first onto a UART byte handshake. Optional lock
//                   timeout enabled by defining FLIT_TX_TIMEOUT_EN.
// Revision 1.0
// ============================================================================
module flit_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int FLIT_W         = 64,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*FLIT_W-1:0]  req_flit,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [7:0]                 uart_data,
   output logic                       uart_trigger,
   input  logic                       uart_full,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       locked,
   output logic                       busy,
   output logic                       pkt_done,
   output logic                       stray_err,
   output logic                       timeout
);

   localparam int BYTES = FLIT_W / 8;
   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int SUM_W = ID_W + 1;
   localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_SEND = 2'd2
   } state_t;

   state_t            state;
   logic [ID_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]  byte_idx;
   logic [FLIT_W-1:0] shreg;
   logic              is_tail;

   logic [FLIT_W-1:0] flits [NUM_REQ];
   logic [ID_W-1:0]   pick;
   logic [ID_W-1:0]   cand;
   logic [ID_W-1:0]   sel;
   logic [ID_W-1:0]   next_ptr;
   logic [SUM_W-1:0]  sum;
   logic              any_valid;
   logic              take;
   logic              accept;
   logic [1:0]        sel_type;
   logic              has_head;
   logic              has_tail;
   logic              last_byte;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign flits[g] = req_flit[g*FLIT_W +: FLIT_W];
   end

   // Descending scan: the smallest offset from rr_ptr is written last and wins.
   always_comb begin
      pick      = rr_ptr;
      any_valid = 1'b0;
      sum       = '0;
      cand      = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         sum = {1'b0, rr_ptr} + SUM_W'(k);
         if (sum >= SUM_W'(NUM_REQ)) begin
            sum = sum - SUM_W'(NUM_REQ);
         end
         cand = sum[ID_W-1:0];
         if (req_valid[cand]) begin
            pick      = cand;
            any_valid = 1'b1;
         end
      end
   end

   always_comb begin
      sel       = locked ? grant_id : pick;
      take      = (state == S_IDLE) && reset &&
                  (locked ? req_valid[grant_id] : any_valid);
      sel_type  = flits[sel][FLIT_W-1 -: 2];
      has_head  = ~(sel_type[1] ^ sel_type[0]);
      has_tail  = sel_type[1];
      accept    = take && (locked || has_head);
      next_ptr  = (pick == ID_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
      last_byte = (byte_idx == IDX_W'(BYTES - 1));
   end

   assign req_ready    = take ? (NUM_REQ'(1) << sel) : '0;
   assign stray_err    = take && !locked && !has_head;
   assign uart_trigger = (state == S_SEND) && !uart_full;
   assign pkt_done     = uart_trigger && last_byte && is_tail;
   assign busy         = (state != S_IDLE) || locked;

`ifdef FLIT_TX_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] to_cnt;
   logic            owner_idle;

   assign owner_idle = (state == S_IDLE) && locked && !req_valid[grant_id];
   assign timeout    = owner_idle && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         to_cnt <= '0;
      end else if (owner_idle) begin
         to_cnt <= timeout ? '0 : to_cnt + 1'b1;
      end else if (take) begin
         to_cnt <= '0;
      end
   end
`else
   logic [31:0] unused_timeout_cycles;

   assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
   assign timeout               = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         rr_ptr    <= '0;
         grant_id  <= '0;
         locked    <= 1'b0;
         is_tail   <= 1'b0;
         byte_idx  <= '0;
         shreg     <= '0;
         uart_data <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  shreg    <= flits[sel];
                  is_tail  <= has_tail;
                  grant_id <= sel;
                  locked   <= 1'b1;
                  state    <= S_LOAD;
                  if (!locked) begin
                     rr_ptr <= next_ptr;
                  end
               end else if (timeout) begin
                  locked <= 1'b0;
               end
            end
            S_LOAD: begin
               byte_idx  <= '0;
               uart_data <= shreg[FLIT_W-1 -: 8];
               shreg     <= shreg << 8;
               state     <= S_SEND;
            end
            S_SEND: begin
               // uart_data already holds the byte being triggered; preload the next one.
               if (uart_trigger) begin
                  uart_data <= shreg[FLIT_W-1 -: 8];
                  shreg     <= shreg << 8;
                  byte_idx  <= byte_idx + 1'b1;
                  if (last_byte) begin
                     state    <= S_IDLE;
                     byte_idx <= '0;
                     if (is_tail) begin
                        locked <= 1'b0;
                     end
                  end
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
